csr_neighbor_fetch_ctrl: RTL
============================

// Module: csr_neighbor_fetch_ctrl
// PURPOSE
// Round-robin scheduler that shares the CSR graph memory among NUM_REQ requesters.
// Per granted vertex v: reads rowptr[v] and rowptr[v+1] from the pointer RAM.
// Then streams colidx[rowptr[v] .. rowptr[v+1]-1] from the dual-port data RAM, two neighbours per beat.
// Each beat is tagged with the requester id; the output FIFO is credit-protected for backpressure.
// PARAMETERS
// NUM_REQ     4   requester count (NUM_REQ <= 2**PROC_BITS)
// PROC_BITS   2   tag width; driven on memory address bits [31+PROC_BITS:32]
// MEM_LAT     2   fixed read latency of both RAMs, addr-valid cycle to data-valid cycle
// FIFO_DEPTH  4   output beat buffer entries (power of 2, >= 2)
// PORTS
// clk_in         in   1                system clock
// rst_in         in   1                synchronous, active-high reset
// req_valid      in   NUM_REQ          per-requester fetch request
// req_vertex     in   NUM_REQ*32       flat vertex ids; requester i at [32*i +: 32]
// req_ready      out  NUM_REQ          one-hot, one-cycle grant; vertex captured on this cycle
// idx_addr       out  32+PROC_BITS     pointer RAM address {tag, vertex}
// idx_validin    out  1                pointer read issue
// data_addra     out  32+PROC_BITS     data RAM port A address {tag, i}
// data_addrb     out  32+PROC_BITS     data RAM port B address {tag, i+1}
// data_validina  out  1                port A read issue
// data_validinb  out  1                port B read issue
// rowidx_in      in   32               pointer RAM read data
// data_ina       in   32               data RAM port A read data
// data_inb       in   32               data RAM port B read data
// out_valid      out  1                FIFO head beat valid
// out_ready      in   1                consumer accepts beat when out_valid & out_ready
// out_nbr_a      out  32               neighbour lane A
// out_nbr_b      out  32               neighbour lane B
// out_lane_valid out  2                bit0 = lane A valid, bit1 = lane B valid
// out_last       out  1                final beat of this vertex's list
// out_tag        out  PROC_BITS        requester id of the beat
// busy           out  1                FSM not in IDLE, or reads in flight, or FIFO non-empty
// err_bad_range  out  1                sticky: a fetch had rowptr[v+1] < rowptr[v]
// BEHAVIOUR
// - Reset: FSM -> IDLE; RR pointer -> 0; FIFO flushed; in-flight read valid pipelines cleared.
//   All outputs 0. RAM data returning after reset is discarded (its pipeline valids are cleared).
// - The memory-side valid outputs are not used. Returned data is tracked by internal MEM_LAT-deep valid/tag/lane shift registers.
// - FSM states:
//   - IDLE: grant the first asserted req_valid at index >= rr_ptr, wrapping. Pulse req_ready[g].
//     Latch vertex and tag = g; set rr_ptr = (g+1) mod NUM_REQ. Next state PTR0.
//   - PTR0: issue idx_addr = v. Next PTR1.
//   - PTR1: issue idx_addr = v+1 (32-bit wrap). Next PWAIT.
//   - PWAIT: capture start when the v read returns and end when the v+1 read returns.
//     When end is captured: if end <= start, go to EMPTY (set err_bad_range if end < start); else i = start, go to STREAM.
//   - STREAM: issue only when fifo_count + inflight_beats < FIFO_DEPTH; otherwise stall with no issue.
//     Each issue: port A reads i; port B reads i+1 only if i+1 < end. Lanes = {i+1<end, 1}. i += 2.
//     The beat covering end-1 carries last = 1; after that issue, go to IDLE.
//   - EMPTY: when a credit is free, push one beat (lanes 00, last 1, tag) directly into the FIFO. Next IDLE.
// - Data issued in cycle t is sampled in cycle t+MEM_LAT and pushed into the FIFO at the end of that cycle.
//   Push pairs data_ina/data_inb with the lanes and tag carried in the pipeline. Lane data with its valid bit 0 is forced to 0.
// - Because of the credit rule, the FIFO never overflows and a push is never dropped. Simultaneous push and pop in one cycle are both legal.
// - Pointer reads for the next request may overlap the drain of the previous one. Beats stay in grant order.
// - A new grant is only given in IDLE; req_valid deasserted before its grant is simply not served.
// - Latency, MEM_LAT=2, no backpressure: first out_valid 2*MEM_LAT+4 = 8 cycles after the req_ready pulse.
//   Then one beat per cycle.
// - Address widths: only the low 32 bits are computed; tag bits are concatenated above them.
// TESTING
// - rowptr[3]=5, rowptr[4]=8, colidx[5..7]=10,11,12; requester 1 asks for v=3
//   -> beat (10,11,lanes 11,last 0,tag 1), then (12,0,lanes 01,last 1); first beat 8 cycles after grant.
// - rowptr[2]=rowptr[3]=7; v=2 -> single beat, lanes 00, last 1; err_bad_range stays 0.
// - All 4 req_valid held high -> grants in order 0,1,2,3,0; req_ready one-hot single-cycle pulses.
// - Degree-9 vertex, out_ready held 0 -> at most FIFO_DEPTH beats buffered, issues stall.
//   Then out_ready=1 -> all 5 beats arrive in order, none lost or duplicated.
// - rowptr[5]=9, rowptr[6]=4 -> single empty last beat; err_bad_range=1 and stays set until rst_in.
// - rst_in pulsed mid-STREAM -> next cycle outputs 0, FSM IDLE; a fresh request then completes with correct data.

Source files
------------

// File: rtl/csr_neighbor_fetch_ctrl.sv
// csr_neighbor_fetch_ctrl: round-robin CSR neighbour-list fetcher with credit-protected output FIFO
module csr_neighbor_fetch_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int PROC_BITS  = 2,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*32-1:0]     req_vertex,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [31+PROC_BITS:0]     idx_addr,
  output logic                      idx_validin,
  output logic [31+PROC_BITS:0]     data_addra,
  output logic [31+PROC_BITS:0]     data_addrb,
  output logic                      data_validina,
  output logic                      data_validinb,
  input  logic [31:0]               rowidx_in,
  input  logic [31:0]               data_ina,
  input  logic [31:0]               data_inb,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_nbr_a,
  output logic [31:0]               out_nbr_b,
  output logic [1:0]                out_lane_valid,
  output logic                      out_last,
  output logic [PROC_BITS-1:0]      out_tag,
  output logic                      busy,
  output logic                      err_bad_range
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, PTR0, PTR1, PWAIT, STREAM, EMPTY} state_t;
  state_t state, state_nx;
  logic [31:0] vtx, start_ptr, end_ptr, cur, rem, gnt_vtx;
  logic [PROC_BITS-1:0] tag, rr_ptr, gnt_idx, lo_idx, hi_idx;
  logic any_lo, any_hi, gnt_found, issue, lane_b, last_beat, credit, empty_push;
  logic ptr_ret, ptr_is_end, push, pop;
  logic [MEM_LAT-1:0] p_v, p_end, d_v, d_lb, d_last;
  logic [PROC_BITS-1:0] d_tag [MEM_LAT];
  logic [31:0] push_a, push_b;
  logic [1:0] push_lanes;
  logic push_last;
  logic [PROC_BITS-1:0] push_tag;
  logic [31:0] f_a [FIFO_DEPTH];
  logic [31:0] f_b [FIFO_DEPTH];
  logic [1:0] f_lanes [FIFO_DEPTH];
  logic f_last [FIFO_DEPTH];
  logic [PROC_BITS-1:0] f_tag [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  int inflight;
  always_comb begin
    any_lo = 1'b0;
    any_hi = 1'b0;
    lo_idx = '0;
    hi_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        any_lo = 1'b1;
        lo_idx = PROC_BITS'(k);
        if (k >= int'(rr_ptr)) begin
          any_hi = 1'b1;
          hi_idx = PROC_BITS'(k);
        end
      end
    end
    gnt_idx = any_hi ? hi_idx : lo_idx;
    gnt_found = any_lo && state == IDLE && !rst_in;
    gnt_vtx = '0;
    for (int k = 0; k < NUM_REQ; k++)
      gnt_vtx = (PROC_BITS'(k) == gnt_idx) ? req_vertex[32*k +: 32] : gnt_vtx;
  end
  // Credits count beats already in the FIFO plus reads whose data has not yet returned.
  always_comb begin
    inflight = 0;
    for (int k = 0; k < MEM_LAT; k++) inflight = inflight + int'(d_v[k]);
    credit = (int'(cnt) + inflight) < FIFO_DEPTH;
    rem = end_ptr - cur;
    lane_b = rem > 32'd1;
    last_beat = rem <= 32'd2;
    issue = state == STREAM && credit;
    empty_push = state == EMPTY && credit && d_v == '0;
    ptr_ret = p_v[MEM_LAT-1];
    ptr_is_end = p_end[MEM_LAT-1];
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = gnt_found ? PTR0 : IDLE;
      PTR0:    state_nx = PTR1;
      PTR1:    state_nx = PWAIT;
      PWAIT:   state_nx = (ptr_ret && ptr_is_end) ? ((rowidx_in <= start_ptr) ? EMPTY : STREAM) : PWAIT;
      STREAM:  state_nx = (issue && last_beat) ? IDLE : STREAM;
      EMPTY:   state_nx = empty_push ? IDLE : EMPTY;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    req_ready = gnt_found ? (NUM_REQ'(1) << gnt_idx) : '0;
    idx_validin = state == PTR0 || state == PTR1;
    idx_addr = idx_validin ? {tag, (state == PTR1) ? vtx + 32'd1 : vtx} : '0;
    data_validina = issue;
    data_validinb = issue && lane_b;
    data_addra = issue ? {tag, cur} : '0;
    data_addrb = data_validinb ? {tag, cur + 32'd1} : '0;
    push = d_v[MEM_LAT-1] || empty_push;
    push_a = d_v[MEM_LAT-1] ? data_ina : '0;
    push_b = (d_v[MEM_LAT-1] && d_lb[MEM_LAT-1]) ? data_inb : '0;
    push_lanes = d_v[MEM_LAT-1] ? {d_lb[MEM_LAT-1], 1'b1} : 2'b00;
    push_last = d_v[MEM_LAT-1] ? d_last[MEM_LAT-1] : 1'b1;
    push_tag = d_v[MEM_LAT-1] ? d_tag[MEM_LAT-1] : tag;
    out_valid = cnt != '0;
    pop = out_valid && out_ready;
    out_nbr_a = out_valid ? f_a[rd_ptr] : '0;
    out_nbr_b = out_valid ? f_b[rd_ptr] : '0;
    out_lane_valid = out_valid ? f_lanes[rd_ptr] : '0;
    out_last = out_valid && f_last[rd_ptr];
    out_tag = out_valid ? f_tag[rd_ptr] : '0;
    busy = state != IDLE || p_v != '0 || d_v != '0 || out_valid;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      rr_ptr <= '0;
      tag <= '0;
      vtx <= '0;
      start_ptr <= '0;
      end_ptr <= '0;
      cur <= '0;
      p_v <= '0;
      p_end <= '0;
      d_v <= '0;
      d_lb <= '0;
      d_last <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      err_bad_range <= 1'b0;
    end else begin
      state <= state_nx;
      if (gnt_found) begin
        vtx <= gnt_vtx;
        tag <= gnt_idx;
        rr_ptr <= (gnt_idx == PROC_BITS'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      p_v <= MEM_LAT'({p_v, idx_validin});
      p_end <= MEM_LAT'({p_end, state == PTR1});
      d_v <= MEM_LAT'({d_v, issue});
      d_lb <= MEM_LAT'({d_lb, lane_b});
      d_last <= MEM_LAT'({d_last, last_beat});
      if (ptr_ret && !ptr_is_end) start_ptr <= rowidx_in;
      if (state == PWAIT && ptr_ret && ptr_is_end) begin
        end_ptr <= rowidx_in;
        cur <= start_ptr;
        err_bad_range <= err_bad_range || rowidx_in < start_ptr;
      end
      if (issue) cur <= cur + 32'd2;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk_in) begin
    d_tag[0] <= tag;
    for (int k = 1; k < MEM_LAT; k++) d_tag[k] <= d_tag[k-1];
    if (push) begin
      f_a[wr_ptr] <= push_a;
      f_b[wr_ptr] <= push_b;
      f_lanes[wr_ptr] <= push_lanes;
      f_last[wr_ptr] <= push_last;
      f_tag[wr_ptr] <= push_tag;
    end
  end
endmodule
